// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of an asynchronous FIFO: synchronizes the write pointer,
// pops words into a registered output stage and reports a conservative fill level.
module fifo_rd_ctrl #(
  parameter int unsigned data_width = 8,
  parameter int unsigned addr_width = 4
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic [addr_width:0]   w_ptr_gray,
  input  logic [data_width-1:0] rd_data_mem,
  input  logic                  out_ready,
  output logic [addr_width-1:0] rd_address,
  output logic                  rd_inc,
  output logic [addr_width:0]   rd_ptr_gray,
  output logic                  empty_flag,
  output logic                  out_valid,
  output logic [data_width-1:0] out_data,
  output logic [addr_width:0]   fill_level
);

  localparam int unsigned PW = addr_width + 1;

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Binary value is the XOR of every right shift of the Gray code.
  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b = g;
    for (int i = 1; i < int'(PW); i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

  logic [PW-1:0]         wq1_q, wq1_d;
  logic [PW-1:0]         wq2_q, wq2_d;
  logic [PW-1:0]         rd_bin_q, rd_bin_d;
  logic [PW-1:0]         rd_ptr_gray_q, rd_ptr_gray_d;
  logic [data_width-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic [PW-1:0]         fill_level_q, fill_level_d;
  logic                  empty_c;
  logic                  pop_c;

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      wq1_q         <= '0;
      wq2_q         <= '0;
      rd_bin_q      <= '0;
      rd_ptr_gray_q <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      fill_level_q  <= '0;
    end else begin
      wq1_q         <= wq1_d;
      wq2_q         <= wq2_d;
      rd_bin_q      <= rd_bin_d;
      rd_ptr_gray_q <= rd_ptr_gray_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      fill_level_q  <= fill_level_d;
    end
  end

  always_comb begin
    wq1_d         = w_ptr_gray;
    wq2_d         = wq1_q;
    rd_bin_d      = rd_bin_q;
    rd_ptr_gray_d = rd_ptr_gray_q;
    out_data_d    = out_data_q;
    out_valid_d   = out_valid_q;
    fill_level_d  = gray2bin(wq2_q) - rd_bin_q;

    empty_c = (rd_ptr_gray_q == wq2_q);
    // Refill the output stage whenever it is empty or being drained this cycle.
    pop_c   = !empty_c && (!out_valid_q || out_ready);

    if (pop_c) begin
      out_data_d    = rd_data_mem;
      out_valid_d   = 1'b1;
      rd_bin_d      = rd_bin_q + PW'(1);
      rd_ptr_gray_d = bin2gray(rd_bin_q + PW'(1));
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  assign rd_address  = rd_bin_q[addr_width-1:0];
  assign rd_inc      = pop_c;
  assign rd_ptr_gray = rd_ptr_gray_q;
  assign empty_flag  = empty_c;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign fill_level  = fill_level_q;

endmodule
